// File: rtl/ysyx_22050039_imem_resp.sv
// Instruction memory with a fixed-latency valid/ready fetch port and a program-load write port.
// Each response carries an error code for misaligned or out-of-range fetch addresses.
module ysyx_22050039_imem_resp #(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     INST_LEN = 32,
   parameter int unsigned     DEPTH    = 1024,
   parameter logic [XLEN-1:0] BASE     = 64'h8000_0000,
   parameter int unsigned     LATENCY  = 2,
   localparam int unsigned    IW       = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [XLEN-1:0]     req_addr,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [INST_LEN-1:0] resp_inst,
   output logic [1:0]          resp_err,
   input  logic                ld_en,
   input  logic [IW-1:0]       ld_addr,
   input  logic [INST_LEN-1:0] ld_data
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic [INST_LEN-1:0] r_mem [DEPTH];
   logic [1:0]          r_state;
   logic [3:0]          r_cnt;
   logic [XLEN-1:0]     r_addr;
   logic                r_req_ready;
   logic                r_resp_valid;
   logic [INST_LEN-1:0] r_inst;
   logic [1:0]          r_err;

   logic [XLEN-1:0]     w_word;
   logic [IW-1:0]       w_idx;
   logic                w_misaligned;
   logic                w_out_range;
   logic [1:0]          w_err;
   logic [INST_LEN-1:0] w_inst;

   assign w_word       = (r_addr - BASE) >> 2;
   assign w_idx        = w_word[IW-1:0];
   assign w_misaligned = |r_addr[1:0];
   // An address below BASE wraps to a huge word offset, so one test covers both range ends.
   assign w_out_range  = |w_word[XLEN-1:IW];

   always_comb begin
      w_err  = 2'b00;
      w_inst = r_mem[w_idx];
      if (w_misaligned) begin
         w_err  = 2'b01;
         w_inst = '0;
      end else if (w_out_range) begin
         w_err  = 2'b10;
         w_inst = '0;
      end
   end

   // Memory shares this block so loads are gated by reset without mixing reset styles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_addr       <= '0;
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_inst       <= '0;
         r_err        <= 2'b00;
      end else begin
         if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
         end
         case (r_state)
            S_IDLE: begin
               r_req_ready <= 1'b1;
               if (req_valid && r_req_ready) begin
                  r_addr      <= req_addr;
                  r_cnt       <= CNT_INIT;
                  r_req_ready <= 1'b0;
                  r_state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_inst       <= w_inst;
                  r_err        <= w_err;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_inst  = r_inst;
   assign resp_err   = r_err;

endmodule

// File: tb/tb_ysyx_22050039_imem_resp.sv
// Bench for ysyx_22050039_imem_resp: directed and random fetches scored against a
// transaction-level memory model; a monitor compares every cycle the DUT presents a response.
module tb_ysyx_22050039_imem_resp;

   localparam int unsigned LATENCY = 2;
   localparam int unsigned DEPTH   = 1024;
   localparam logic [63:0] BASE    = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_inst;
   logic [1:0]  resp_err;
   logic        ld_en;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference state: memory image, pending fetch and its due edge, expected responses.
   logic [31:0] mem_m [DEPTH];
   logic [63:0] m_addr;
   int          due = -1;
   int          since_rst = 0;
   logic [33:0] exp_q [$];

   ysyx_22050039_imem_resp #(
      .XLEN    (64),
      .INST_LEN(32),
      .DEPTH   (DEPTH),
      .BASE    (BASE),
      .LATENCY (LATENCY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_inst (resp_inst),
      .resp_err  (resp_err),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // {err, inst} for a fetch of byte address a, from the current memory image.
   function automatic logic [33:0] ref_resp(input logic [63:0] a);
      logic [63:0] lim;
      logic [63:0] word;
      logic [9:0]  idx;
      lim = BASE + 64'(4 * DEPTH);
      if (a[1:0] != 2'b00) return {2'b01, 32'h0};
      if (a < BASE || a >= lim) return {2'b10, 32'h0};
      word = (a - BASE) / 4;
      idx  = word[9:0];
      return {2'b00, mem_m[idx]};
   endfunction

   // Monitor and model: looks at pin values just before each rising edge.
   initial begin
      logic m_ready;
      forever begin
         @(posedge clk);
         if (!rst) begin
            check("rst_req_ready", req_ready, 1'b0);
            check("rst_resp_valid", resp_valid, 1'b0);
            check("rst_resp_inst", resp_inst, 32'h0);
            check("rst_resp_err", resp_err, 2'b00);
            due = -1;
            exp_q.delete();
            since_rst = 0;
         end else begin
            m_ready = (since_rst > 0) && (due < 0) && (exp_q.size() == 0);
            check("req_ready", req_ready, m_ready);
            check("resp_valid", resp_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
               check("resp_inst", resp_inst, exp_q[0][31:0]);
               check("resp_err", resp_err, exp_q[0][33:32]);
               if (resp_ready) void'(exp_q.pop_front());
            end
            if (due >= 0 && cyc == due) begin
               exp_q.push_back(ref_resp(m_addr));
               due = -1;
            end
            if (req_valid && m_ready) begin
               m_addr = req_addr;
               due    = cyc + LATENCY;
            end
            if (ld_en) mem_m[ld_addr] = ld_data;
            since_rst++;
         end
         cyc++;
      end
   end

   // Returns at the falling edge after the accepting rising edge.
   task automatic issue(input logic [63:0] a);
      int t = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("issue_accept", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int t = 0;
      while (!resp_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("resp_arrive", resp_valid, 1'b1);
   endtask

   task automatic drain(input int hold, input bit noise);
      resp_ready = 1'b0;
      wait_valid();
      if (noise) begin
         req_valid = 1'b1;
         req_addr  = BASE + 64'h20;
      end
      repeat (hold) @(negedge clk);
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic fetch(input logic [63:0] a);
      issue(a);
      drain(0, 1'b0);
   endtask

   initial begin
      logic [63:0] a;
      rst = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
         @(negedge clk);
         ld_en   = 1'b1;
         ld_addr = 10'(i);
         ld_data = (i == 0) ? 32'h0000_0413 : $urandom;
      end
      @(negedge clk);
      ld_en = 1'b0;

      fetch(BASE);
      fetch(BASE + 64'h2);
      fetch(BASE - 64'h4);
      fetch(BASE + 64'h1000);
      fetch(BASE + 64'hFFC);

      // Backpressure with a competing request held high.
      issue(BASE + 64'h4);
      drain(5, 1'b1);

      // Load earlier in the wait window is seen by the fetch.
      issue(BASE + 64'h10);
      ld_en = 1'b1; ld_addr = 10'd4; ld_data = 32'h1234_5678;
      @(negedge clk);
      ld_en = 1'b0;
      drain(0, 1'b0);

      // Load on the capture edge: old word first, new word on the next fetch.
      issue(BASE + 64'hC);
      repeat (LATENCY - 1) @(negedge clk);
      ld_en = 1'b1; ld_addr = 10'd3; ld_data = 32'hDEAD_BEEF;
      @(negedge clk);
      ld_en = 1'b0;
      drain(0, 1'b0);
      fetch(BASE + 64'hC);

      // Reset mid-wait drops the fetch; loads during reset are ignored.
      issue(BASE);
      rst = 1'b0;
      #1;
      check("rst_wait_resp_valid", resp_valid, 1'b0);
      check("rst_wait_req_ready", req_ready, 1'b0);
      ld_en = 1'b1; ld_addr = 10'd0; ld_data = 32'h0BAD_0BAD;
      repeat (2) @(negedge clk);
      ld_en = 1'b0;
      rst = 1'b1;
      resp_ready = 1'b1;
      repeat (6) @(negedge clk);
      resp_ready = 1'b0;
      fetch(BASE);

      // Reset while the response is presented.
      issue(BASE + 64'h8);
      wait_valid();
      rst = 1'b0;
      #1;
      check("rst_resp_resp_valid", resp_valid, 1'b0);
      check("rst_resp_resp_inst", resp_inst, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         case ($urandom_range(0, 9))
            0:       a = BASE + 64'($urandom_range(0, 4095));
            1:       a = BASE - 64'(4 * $urandom_range(1, 8));
            2:       a = BASE + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 8));
            default: a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
         endcase
         rst        = ($urandom_range(0, 299) != 0);
         req_valid  = $urandom_range(0, 1) == 1;
         req_addr   = a;
         resp_ready = $urandom_range(0, 3) != 0;
         ld_en      = $urandom_range(0, 3) == 0;
         ld_addr    = 10'($urandom_range(0, DEPTH - 1));
         ld_data    = $urandom;
      end

      @(negedge clk);
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; ld_en = 1'b0;
      repeat (20) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ysyx_22050039_imem_resp.md
YSYX_22050039_IMEM_RESP -- requirements
Module: ysyx_22050039_imem_resp

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, address width.
REQ-002 The block SHALL have parameter INST_LEN, default 32, instruction width.
REQ-003 The block SHALL have parameter DEPTH, default 1024, instruction words stored; power of two.
REQ-004 The block SHALL have parameter BASE, default 64'h8000_0000, byte address of word 0.
REQ-005 The block SHALL have parameter LATENCY, default 2, request-accept-to-response cycles; legal range 1..15.
REQ-006 The block SHALL have one clock, clk; reset is asynchronous and active-low, port rst.
REQ-007 clk  input  1  clock; all state changes on the rising edge.
REQ-008 rst  input  1  asynchronous active-low reset.
REQ-009 req_valid  input  1  fetch request present.
REQ-010 req_ready  output  1  block can accept a request.
REQ-011 req_addr  input  XLEN  fetch byte address (the CPU pc).
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  consumer accepts the response.
REQ-014 resp_inst  output  INST_LEN  fetched instruction.
REQ-015 resp_err  output  2  00 ok, 01 misaligned, 10 out of range.
REQ-016 ld_en  input  1  program-load write enable.
REQ-017 ld_addr  input  log2(DEPTH)  program-load word index.
REQ-018 ld_data  input  INST_LEN  program-load word.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-020 IDLE: req_ready=1 and resp_valid=0; a handshake (req_valid&req_ready) SHALL latch req_addr, load the counter with LATENCY-1, and enter WAIT.
REQ-021 WAIT: req_ready=0 and resp_valid=0; the counter decrements each cycle; at counter 0 the block SHALL capture the data and error code into output registers and enter RESP.
REQ-022 Response timing: a request accepted at edge N SHALL produce resp_valid=1 after edge N+LATENCY.
REQ-023 RESP: resp_valid=1 and req_ready=0; resp_inst and resp_err SHALL stay stable until resp_ready=1; the handshake edge SHALL return the FSM to IDLE.
REQ-024 Back-to-back: a new request SHALL NOT be accepted in the same cycle as the response handshake; req_valid in WAIT or RESP SHALL be ignored.
REQ-025 The word index SHALL be (addr-BASE)>>2, using XLEN-bit unsigned arithmetic.
REQ-026 If addr[1:0]!=0, resp_err SHALL be 01; this check takes priority over the range check.
REQ-027 If addr<BASE or addr>=BASE+4*DEPTH, resp_err SHALL be 10.
REQ-028 Any error response SHALL return resp_inst=0 and SHALL still take LATENCY cycles.
REQ-029 ld_en=1 SHALL write ld_data to the word at ld_addr on that edge, in any FSM state.
REQ-030 A load to the index being captured on the same edge SHALL return the old data (read-before-write).
REQ-031 A load to that index earlier in WAIT SHALL return the new data.

Reset
REQ-032 While rst=0, the FSM SHALL be IDLE, the counter 0, and the outputs req_ready=0, resp_valid=0, resp_inst=0, resp_err=00.
REQ-033 The cycle after rst rises, req_ready SHALL be 1.
REQ-034 Reset mid-WAIT or mid-RESP SHALL drop the pending transaction immediately; no response SHALL follow.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 ld_en SHALL be ignored while rst=0.

Verification
REQ-037 Basic fetch: load index 0 = 32'h0000_0413, request 0x8000_0000, LATENCY=2 -> resp_valid after 2 edges, resp_inst=0000_0413, resp_err=00.
REQ-038 Misaligned: request 0x8000_0002 -> resp_err=01, resp_inst=0, after LATENCY cycles.
REQ-039 Out of range: requests 0x7FFF_FFFC and 0x8000_1000 (DEPTH=1024) -> resp_err=10 each; 0x8000_0FFC -> resp_err=00.
REQ-040 Backpressure: hold resp_ready=0 for 5 cycles with req_valid=1 -> resp_valid, resp_inst and resp_err stable, req_ready=0, no second request accepted.
REQ-041 Reset: drive rst=0 during WAIT -> resp_valid=0 immediately and no later response; after release a fetch of index 0 returns the pre-reset contents.
REQ-042 Load collision: write index 3 with 0xDEAD_BEEF on the capture edge of a fetch of 0x8000_000C -> old word returned; a second fetch -> 0xDEAD_BEEF.
